// File: rtl/ysyx_040729_trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states, cause codes,
// CSR addresses and the mtvec mode field.
package ysyx_040729_trap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_e;

   localparam logic [3:0] EXC_ILLEGAL = 4'd2;
   localparam logic [3:0] EXC_ECALL_M = 4'd11;
   localparam logic [3:0] IRQ_MEI     = 4'd11;
   localparam logic [3:0] IRQ_MTI     = 4'd7;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/ysyx_040729_trap_target.sv
// Combinational redirect-target calculation from mtvec/mepc and the latched cause.
// Vectored interrupt dispatch is built only when TRAP_VECTORED_EN is defined.
module ysyx_040729_trap_target
   import ysyx_040729_trap_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] mtvec,
   input  logic [DATA_WIDTH-1:0] mepc,
   input  logic                  is_mret,
   input  logic                  is_irq,
   input  logic [3:0]            code,
   output logic [DATA_WIDTH-1:0] target
);

   logic [DATA_WIDTH-1:0] base;
   assign base = {mtvec[DATA_WIDTH-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   logic vec_mode;
   assign vec_mode = (mtvec[1:0] == MTVEC_VECTORED);

   always_comb begin
      target = base;
      if (is_mret) begin
         target = mepc;
      end else if (is_irq && vec_mode) begin
         // Interrupts dispatch to base + 4*cause; exceptions always land on base.
         target = base + {{(DATA_WIDTH-6){1'b0}}, code, 2'b00};
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{mtvec[1:0], is_irq, code};

   always_comb begin
      target = is_mret ? mepc : base;
   end
`endif

endmodule

// File: rtl/ysyx_040729_trap_ctrl.sv
// Trap sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT for exceptions, mret and interrupts.
// Optional vectored interrupt targets via TRAP_VECTORED_EN (see ysyx_040729_trap_target).
module ysyx_040729_trap_ctrl
   import ysyx_040729_trap_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  commit_valid,
   input  logic [DATA_WIDTH-1:0] commit_pc,
   input  logic [DATA_WIDTH-1:0] commit_next_pc,
   input  logic                  exc_req,
   input  logic [3:0]            exc_code,
   input  logic                  mret_req,
   input  logic                  eirp_i,
   input  logic                  tirp_i,
   input  logic                  pipe_idle,
   input  logic [DATA_WIDTH-1:0] csr_mtvec,
   input  logic [DATA_WIDTH-1:0] csr_mepc,
   output logic                  exception_o,
   output logic                  mret_o,
   output logic                  flow_o,
   output logic [DATA_WIDTH-1:0] mepc_hwdata,
   output logic [DATA_WIDTH-1:0] mcause_hwdata,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ready,
   output logic                  drain_err_o
);

   localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

   trap_state_e           state_q, state_d;
   logic [CNT_W-1:0]      drain_cnt_q;
   logic                  drain_timeout, drain_done, detect;
   logic                  take_mret, take_irq;
   logic [3:0]            code_d;
   logic                  is_mret_q, is_irq_q, drain_err_q;
   logic [3:0]            code_q;
   logic [DATA_WIDTH-1:0] mepc_q, mcause_q, target_q, target_w;

   assign drain_timeout = (drain_cnt_q == CNT_W'(DRAIN_TIMEOUT));
   assign drain_done    = pipe_idle || drain_timeout;
   assign detect        = (state_q == ST_IDLE) && commit_valid &&
                          (exc_req || mret_req || eirp_i || tirp_i);

   // Cause priority at commit: exception > mret > external > timer.
   always_comb begin
      take_mret = 1'b0;
      take_irq  = 1'b0;
      code_d    = 4'd0;
      if (exc_req) begin
         code_d = exc_code;
      end else if (mret_req) begin
         take_mret = 1'b1;
      end else if (eirp_i) begin
         take_irq = 1'b1;
         code_d   = IRQ_MEI;
      end else if (tirp_i) begin
         take_irq = 1'b1;
         code_d   = IRQ_MTI;
      end
   end

   always_comb begin
      state_d        = state_q;
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      exception_o    = 1'b0;
      mret_o         = 1'b0;
      redirect_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (detect) begin
               stall_o = 1'b1;
               flush_o = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            stall_o = 1'b1;
            if (drain_done) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            stall_o     = 1'b1;
            exception_o = !is_mret_q;
            mret_o      = is_mret_q;
            state_d     = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            stall_o        = 1'b1;
            redirect_valid = 1'b1;
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   ysyx_040729_trap_target #(.DATA_WIDTH(DATA_WIDTH)) u_target (
      .mtvec   (csr_mtvec),
      .mepc    (csr_mepc),
      .is_mret (is_mret_q),
      .is_irq  (is_irq_q),
      .code    (code_q),
      .target  (target_w)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= '0;
         drain_err_q <= 1'b0;
         is_mret_q   <= 1'b0;
         is_irq_q    <= 1'b0;
         code_q      <= 4'd0;
         mepc_q      <= '0;
         mcause_q    <= '0;
         target_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DRAIN) begin
            drain_cnt_q <= drain_done ? '0 : drain_cnt_q + CNT_W'(1);
            if (drain_timeout && !pipe_idle) drain_err_q <= 1'b1;
         end
         if (detect) begin
            is_mret_q <= take_mret;
            is_irq_q  <= take_irq;
            code_q    <= code_d;
            // Interrupts resume after the retiring instruction; mret leaves mepc/mcause alone.
            if (!take_mret) begin
               mepc_q   <= take_irq ? commit_next_pc : commit_pc;
               mcause_q <= {take_irq, {(DATA_WIDTH-5){1'b0}}, code_d};
            end
         end
         if (state_q == ST_COMMIT) target_q <= target_w;
      end
   end

   assign flow_o        = exception_o | mret_o;
   assign mepc_hwdata   = mepc_q;
   assign mcause_hwdata = mcause_q;
   assign redirect_pc   = target_q;
   assign drain_err_o   = drain_err_q;

endmodule

// File: tb/tb_ysyx_040729_trap_ctrl.sv
// Self-checking bench for ysyx_040729_trap_ctrl: directed vectors plus randomized traps
// compared against a cause/target reference model.
module tb_ysyx_040729_trap_ctrl;

   localparam int DW = 64;
   localparam int TO = 255;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          commit_valid, exc_req, mret_req, eirp_i, tirp_i, pipe_idle, redirect_ready;
   logic [3:0]    exc_code;
   logic [DW-1:0] commit_pc, commit_next_pc, csr_mtvec, csr_mepc;
   logic          exception_o, mret_o, flow_o, stall_o, flush_o, redirect_valid, drain_err_o;
   logic [DW-1:0] mepc_hwdata, mcause_hwdata, redirect_pc;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ysyx_040729_trap_ctrl #(.DATA_WIDTH(DW), .DRAIN_TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
      .exc_req(exc_req), .exc_code(exc_code), .mret_req(mret_req),
      .eirp_i(eirp_i), .tirp_i(tirp_i), .pipe_idle(pipe_idle),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .exception_o(exception_o), .mret_o(mret_o), .flow_o(flow_o),
      .mepc_hwdata(mepc_hwdata), .mcause_hwdata(mcause_hwdata),
      .stall_o(stall_o), .flush_o(flush_o),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .drain_err_o(drain_err_o)
   );

   // Architectural expectation for one trap, from the priority and target rules.
   function automatic void ref_model(input bit exc, input logic [3:0] code, input bit mret,
                                     input bit ei, input bit ti,
                                     input logic [DW-1:0] pc, input logic [DW-1:0] npc,
                                     input logic [DW-1:0] mtvec, input logic [DW-1:0] mepc,
                                     output bit is_mret, output logic [DW-1:0] e_mepc,
                                     output logic [DW-1:0] e_mcause, output logic [DW-1:0] e_tgt);
      logic [DW-1:0] base;
      int irq_code;
      base     = mtvec - (mtvec % 4);
      is_mret  = 1'b0;
      e_mepc   = '0;
      e_mcause = '0;
      e_tgt    = base;
      if (exc) begin
         e_mepc   = pc;
         e_mcause = DW'(code);
      end else if (mret) begin
         is_mret = 1'b1;
         e_tgt   = mepc;
      end else begin
         irq_code = ei ? 11 : 7;
         if (!ei && !ti) irq_code = 7;
         e_mepc   = npc;
         e_mcause = (64'd1 << 63) + DW'(irq_code);
`ifdef TRAP_VECTORED_EN
         if (mtvec % 4 == 1) e_tgt = base + DW'(4 * irq_code);
`endif
      end
   endfunction

   task automatic drive_idle();
      commit_valid = 1'b0; exc_req = 1'b0; exc_code = 4'd0; mret_req = 1'b0;
      eirp_i = 1'b0; tirp_i = 1'b0; commit_pc = '0; commit_next_pc = '0;
      pipe_idle = 1'b1; redirect_ready = 1'b0;
   endtask

   task automatic run_trap(input string tag, input bit exc, input logic [3:0] code, input bit mret,
                           input bit ei, input bit ti, input logic [DW-1:0] pc,
                           input logic [DW-1:0] npc, input logic [DW-1:0] mtvec,
                           input logic [DW-1:0] mepc, input int idle_dly, input int rdy_dly,
                           input bit noise);
      bit            x_mret;
      logic [DW-1:0] x_mepc, x_mcause, x_tgt;
      ref_model(exc, code, mret, ei, ti, pc, npc, mtvec, mepc, x_mret, x_mepc, x_mcause, x_tgt);
      @(posedge clock); #1;
      commit_valid = 1'b1; exc_req = exc; exc_code = code; mret_req = mret;
      eirp_i = ei; tirp_i = ti; commit_pc = pc; commit_next_pc = npc;
      csr_mtvec = mtvec; csr_mepc = mepc; pipe_idle = 1'b0; redirect_ready = 1'b0;
      @(negedge clock);
      checks++;
      if ({stall_o, flush_o, flow_o, redirect_valid} !== 4'b1100) begin
         errors++;
         $display("FAIL %s detect stall/flush/flow/rv got %b exp 1100", tag,
                  {stall_o, flush_o, flow_o, redirect_valid});
      end
      for (int i = 0; i <= idle_dly; i++) begin
         @(posedge clock); #1;
         if (noise) begin
            commit_valid = 1'b1; exc_req = 1'($urandom); exc_code = 4'($urandom);
            mret_req = 1'($urandom); eirp_i = 1'($urandom); tirp_i = 1'($urandom);
            commit_pc = {$urandom, $urandom}; commit_next_pc = {$urandom, $urandom};
         end else begin
            commit_valid = 1'b0; exc_req = 1'b0; mret_req = 1'b0; eirp_i = 1'b0; tirp_i = 1'b0;
         end
         pipe_idle = (i == idle_dly);
         @(negedge clock);
         checks++;
         if ({stall_o, flush_o, flow_o} !== 3'b100) begin
            errors++;
            $display("FAIL %s drain%0d stall/flush/flow got %b exp 100", tag, i,
                     {stall_o, flush_o, flow_o});
         end
      end
      @(posedge clock); #1;
      commit_valid = 1'b0; exc_req = 1'b0; mret_req = 1'b0; eirp_i = 1'b0; tirp_i = 1'b0;
      pipe_idle = 1'b1;
      @(negedge clock);
      checks++;
      if ({exception_o, mret_o, flow_o, stall_o, redirect_valid} !== {!x_mret, x_mret, 3'b110}) begin
         errors++;
         $display("FAIL %s commit exc/mret/flow/stall/rv got %b exp %b", tag,
                  {exception_o, mret_o, flow_o, stall_o, redirect_valid}, {!x_mret, x_mret, 3'b110});
      end
      if (!x_mret) begin
         checks++;
         if (mepc_hwdata !== x_mepc || mcause_hwdata !== x_mcause) begin
            errors++;
            $display("FAIL %s hwdata mepc %h mcause %h exp %h %h", tag,
                     mepc_hwdata, mcause_hwdata, x_mepc, x_mcause);
         end
      end
      for (int i = 0; i <= rdy_dly; i++) begin
         @(posedge clock); #1;
         redirect_ready = (i == rdy_dly);
         @(negedge clock);
         checks++;
         if (redirect_valid !== 1'b1 || stall_o !== 1'b1 || flow_o !== 1'b0 || redirect_pc !== x_tgt) begin
            errors++;
            $display("FAIL %s redirect%0d rv %b stall %b flow %b pc %h exp 1 1 0 %h", tag, i,
                     redirect_valid, stall_o, flow_o, redirect_pc, x_tgt);
         end
      end
      @(posedge clock); #1;
      redirect_ready = 1'b0;
      @(negedge clock);
      checks++;
      if ({redirect_valid, stall_o, flush_o} !== 3'b000) begin
         errors++;
         $display("FAIL %s back_idle rv/stall/flush got %b exp 000", tag,
                  {redirect_valid, stall_o, flush_o});
      end
   endtask

   task automatic test_reset();
      drive_idle();
      csr_mtvec = '0; csr_mepc = '0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({exception_o, mret_o, flow_o, stall_o, flush_o, redirect_valid, drain_err_o} !== 7'b0 ||
          redirect_pc !== '0 || mepc_hwdata !== '0 || mcause_hwdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ctl %b pc %h mepc %h mcause %h exp all 0",
                  {exception_o, mret_o, flow_o, stall_o, flush_o, redirect_valid, drain_err_o},
                  redirect_pc, mepc_hwdata, mcause_hwdata);
      end
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic test_no_trap();
      @(posedge clock); #1;
      commit_valid = 1'b1; commit_pc = 64'h8000_0400;
      @(negedge clock);
      checks++;
      if ({stall_o, flush_o} !== 2'b00) begin
         errors++;
         $display("FAIL plain_commit stall/flush got %b exp 00", {stall_o, flush_o});
      end
      @(posedge clock); #1;
      commit_valid = 1'b0; eirp_i = 1'b1; tirp_i = 1'b1;
      @(negedge clock);
      checks++;
      if ({stall_o, flush_o} !== 2'b00) begin
         errors++;
         $display("FAIL irq_no_commit stall/flush got %b exp 00", {stall_o, flush_o});
      end
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      checks++;
      if ({stall_o, redirect_valid, flow_o} !== 3'b000) begin
         errors++;
         $display("FAIL irq_no_commit_after got %b exp 000", {stall_o, redirect_valid, flow_o});
      end
   endtask

   task automatic test_directed();
      run_trap("ecall", 1, 4'd11, 0, 0, 0, 64'h8000_0100, 64'h8000_0104,
               64'h8000_0004, 64'h0, 0, 0, 0);
      run_trap("timer", 0, 4'd0, 0, 0, 1, 64'h8000_0200, 64'h8000_0204,
               64'h8000_0004, 64'h0, 1, 1, 0);
      run_trap("exc_over_irq", 1, 4'd2, 0, 1, 0, 64'h8000_0208, 64'h8000_020c,
               64'h8000_0004, 64'h0, 0, 0, 0);
      run_trap("mret", 0, 4'd0, 1, 0, 1, 64'h8000_0210, 64'h8000_0214,
               64'h8000_0004, 64'h8000_0300, 2, 0, 1);
      run_trap("ext_after_mret", 0, 4'd0, 0, 1, 1, 64'h8000_0300, 64'h8000_0304,
               64'h8000_0001, 64'h8000_0300, 0, 2, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         bit            e, m, ei, ti;
         logic [DW-1:0] pc;
         e  = ($urandom % 3) == 0;
         m  = ($urandom % 3) == 0;
         ei = 1'($urandom);
         ti = 1'($urandom);
         if (!e && !m && !ei) ti = 1'b1;
         pc = {32'h0, $urandom} & ~64'h3;
         run_trap("random", e, 4'($urandom), m, ei, ti, pc, pc + 64'd4,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom % 5), int'($urandom % 4), 1'($urandom));
      end
   endtask

   task automatic test_drain_timeout();
      int n;
      @(posedge clock); #1;
      commit_valid = 1'b1; exc_req = 1'b1; exc_code = 4'd2; commit_pc = 64'h8000_0500;
      csr_mtvec = 64'h8000_0000; pipe_idle = 1'b0;
      @(posedge clock); #1;
      drive_idle();
      pipe_idle = 1'b0;
      n = 1;
      @(negedge clock);
      while (exception_o !== 1'b1 && n < 1000) begin
         @(posedge clock); #1;
         @(negedge clock);
         if (exception_o !== 1'b1) n++;
      end
      checks++;
      if (n != TO + 1) begin
         errors++;
         $display("FAIL drain_timeout_cycles got %0d exp %0d", n, TO + 1);
      end
      checks++;
      if (drain_err_o !== 1'b1) begin
         errors++;
         $display("FAIL drain_err_set got %b exp 1", drain_err_o);
      end
      @(posedge clock); #1;
      pipe_idle = 1'b1; redirect_ready = 1'b1;
      @(posedge clock); #1;
      redirect_ready = 1'b0;
      run_trap("after_timeout", 1, 4'd11, 0, 0, 0, 64'h8000_0600, 64'h8000_0604,
               64'h8000_0100, 64'h0, 0, 0, 0);
      checks++;
      if (drain_err_o !== 1'b1) begin
         errors++;
         $display("FAIL drain_err_sticky got %b exp 1", drain_err_o);
      end
   endtask

   task automatic test_reset_redirect();
      @(posedge clock); #1;
      commit_valid = 1'b1; exc_req = 1'b1; exc_code = 4'd11; commit_pc = 64'h8000_0700;
      csr_mtvec = 64'h8000_0004; pipe_idle = 1'b1;
      @(posedge clock); #1;
      drive_idle();
      repeat (2) @(posedge clock);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0004) begin
            errors++;
            $display("FAIL hold_redirect%0d rv %b pc %h exp 1 %h", i, redirect_valid,
                     redirect_pc, 64'h8000_0004);
         end
         @(posedge clock);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({exception_o, mret_o, flow_o, stall_o, flush_o, redirect_valid, drain_err_o} !== 7'b0 ||
          redirect_pc !== '0 || mepc_hwdata !== '0 || mcause_hwdata !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs ctl %b pc %h mepc %h mcause %h exp all 0",
                  {exception_o, mret_o, flow_o, stall_o, flush_o, redirect_valid, drain_err_o},
                  redirect_pc, mepc_hwdata, mcause_hwdata);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({redirect_valid, stall_o} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_idle rv/stall got %b exp 00", {redirect_valid, stall_o});
      end
   endtask

   initial begin
      test_reset();
      test_no_trap();
      test_directed();
      test_back_to_back();
      test_drain_timeout();
      test_reset_redirect();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
